// File: rtl/trade_order_queue.sv
// trade_order_queue: turns a level-held arbitrage trigger into de-duplicated, rate-limited buy
// orders buffered in a first-word-fall-through FIFO. Define TRADE_ORDER_SEQ_EN for sequence tags.
module trade_order_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned COOLDOWN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trade_trigger,
  input  logic [63:0]               trade_price,
  output logic                      order_valid,
  input  logic                      order_ready,
  output logic [63:0]               order_price,
`ifdef TRADE_ORDER_SEQ_EN
  output logic [15:0]               order_seq,
`endif
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [15:0]               drop_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [7:0]  CD_LOAD  = COOLDOWN[7:0];

  logic          prev_trig;
  logic [63:0]   last_price;
  logic [7:0]    cd_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   price_mem [DEPTH];

  logic candidate;
  logic capture;
  logic pop;
  logic push;
  logic drop;

  // A held trigger only re-arms when the qualifying price moves.
  always_comb begin
    candidate = trade_trigger && (!prev_trig || (trade_price != last_price));
    capture   = candidate && (cd_cnt == '0);
    pop       = order_valid && order_ready;
    push      = capture && ((fifo_count != FULL_CNT) || pop);
    drop      = capture && !push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_trig  <= 1'b0;
      last_price <= '0;
      cd_cnt     <= '0;
    end else begin
      prev_trig <= trade_trigger;
      if (capture) begin
        last_price <= trade_price;
        cd_cnt     <= CD_LOAD;
      end else if (cd_cnt != '0) begin
        cd_cnt <= cd_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) price_mem[wr_ptr] <= trade_price;
  end

  assign order_valid = (fifo_count != '0);
  // Head is masked while empty so the outputs read zero straight out of reset.
  assign order_price = order_valid ? price_mem[rd_ptr] : '0;

`ifdef TRADE_ORDER_SEQ_EN
  logic [15:0] seq_cnt;
  logic [15:0] seq_next;
  logic [15:0] seq_mem [DEPTH];

  assign seq_next = seq_cnt + 16'd1;

  // Dropped captures still consume a number so the consumer can detect gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seq_cnt <= '0;
    else if (capture) seq_cnt <= seq_next;
  end

  always_ff @(posedge clk) begin
    if (push) seq_mem[wr_ptr] <= seq_next;
  end

  assign order_seq = order_valid ? seq_mem[rd_ptr] : '0;
`endif

endmodule
